parsed_token_arb: RTL and testbench
===================================

# parsed_token_arb

Round-robin, packet-locked arbiter that lets up to four upstream token producers share one parsed-token queue. It sits between the Huffman-decode producers and the input side of the parsed-token queue page. A stream is granted and held until it sends an end-of-stream-flagged token, or until an optional burst limit is reached. It presents one registered output stage using the queue's valid/backpressure handshake.

## Interface
Parameters:
- `W`, 16: token data width.
- `N`, 2: number of requesters, legal range 2..4.
- `MAXBURST`, 0: maximum tokens per grant; 0 means unlimited (release only on e=1).

Ports:
- `clock`  in  1: single clock; all state on rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `in_d`  in  N*W: requester data; requester i occupies `[i*W +: W]`.
- `in_e`  in  N: per-requester end-of-stream flag accompanying data.
- `in_v`  in  N: per-requester valid.
- `in_b`  out  N: per-requester backpressure; 1 = not accepting.
- `qout_d`  out  W: token data to queue.
- `qout_e`  out  1: end-of-stream flag to queue.
- `qout_v`  out  1: output valid.
- `qout_b`  in  1: queue backpressure; 1 = queue full.
- `grant`  out  2: index of the currently locked requester; valid when `busy`=1.
- `busy`  out  1: 1 while in LOCKED.

## Operation
- Transfer rules: an input transfer occurs when `in_v[i]` && !`in_b[i]`; an output transfer occurs when `qout_v` && !`qout_b`.
- Output stage is a single register (d, e, v). `room` = !`qout_v` || !`qout_b`.
- FSM has two states.
  - **IDLE**: `in_b` is all ones. If any `in_v` is set, select the first set index scanning from `ptr` upward, modulo N. Register it into `grant`, clear `cnt`, and go to LOCKED. Otherwise stay in IDLE.
  - **LOCKED**: `in_b[grant]` = !`room`; all other `in_b` bits are 1. On an accepted token, load the output register and increment `cnt`.
  - Release condition: the accepted token has e=1, or (MAXBURST≠0 and `cnt`+1 == MAXBURST). On release, go to IDLE and set `ptr` ← (`grant`+1) mod N.
- If `room` holds but no token is accepted, the output register clears v. If `room` is false, the output register holds.
- `cnt` is wide enough for MAXBURST (minimum 8 bits) and saturates harmlessly when MAXBURST=0.
- A requester dropping `in_v` while locked does not release the grant. The lock persists until e=1 or the burst limit.
- Reset values: state=IDLE, `ptr`=0, `grant`=0, `cnt`=0, `qout_v`=0, `qout_d`=0, `qout_e`=0, `in_b`=all ones, `busy`=0.
- Reset asserted mid-packet drops the output register contents and the lock. Upstream must re-send from its own restart point.

## Timing
- Arbitration costs 1 cycle: a request seen in IDLE at cycle t is granted at t+1, and its first token can be accepted at t+1.
- Input-to-output latency is 1 cycle: a token accepted at cycle t appears on `qout_*` at t+1.
- Steady-state throughput is 1 token/cycle while `qout_b`=0.
- When `qout_b`=1 with `qout_v`=1, `in_b[grant]`=1 in the same cycle, so the path is combinational from `qout_b` to `in_b`. No token is lost or duplicated.
- Release-to-next-grant gap is exactly 1 IDLE cycle. The last token of the old packet and the first of the new are never on the output in adjacent cycles unless the IDLE cycle is covered by a stall.
- Simultaneous requests in IDLE are resolved by round-robin from `ptr`. If `in_v` is set on the released requester alone, it is re-granted after 1 IDLE cycle.

## Structure
- Shared package holds: the token width constant (16), the handshake encoding note (b=1 means stall), and the FSM state encoding (IDLE=0, LOCKED=1).
- One sub-module, `rr_pick`: a combinational N-way round-robin first-set finder with inputs (`req`, `ptr`) and outputs (`idx`, `any`). Everything else lives in the top module.

## Test plan
- **Single requester, N=2, MAXBURST=0.** Req0 sends 0x0011, 0x0022, 0x0033(e=1) with `qout_b`=0. Required: `qout` shows the three tokens on consecutive cycles starting 1 cycle after grant, and `busy` drops after the e=1 token.
- **Contention.** Req0 and Req1 both valid from reset with 2-token packets. Required: req0 is granted first (`ptr`=0), then req1, then req0. Output order is A0,A1,B0,B1,A0',A1'.
- **Backpressure.** Hold `qout_b`=1 for 3 cycles mid-packet. Required: `qout_d` is stable, `in_b[grant]`=1 during the stall, and no token is dropped or duplicated.
- **Burst limit, MAXBURST=4.** Req1 streams 10 tokens with no e while req0 waits. Required: the grant switches to req0 after exactly 4 req1 tokens.
- **Idle requester while locked.** Req0 drops `in_v` for 5 cycles mid-packet while req1 is valid. Required: the grant stays 0 and `in_b[1]`=1 throughout.
- **Reset mid-packet.** Assert `reset`=0 during a LOCKED transfer. Required: `qout_v`=0, `in_b`=all ones, `busy`=0 asynchronously, and arbitration restarts from `ptr`=0.

Source files
------------

// File: rtl/parsed_token_arb_pkg.sv
// Shared definitions for the parsed-token arbiter: token width, handshake sense
// and FSM encoding.
package parsed_token_arb_pkg;

  localparam int TOKEN_W = 16;

  // Handshake sense: b=1 means the receiver stalls; a transfer is v && !b.
  localparam logic STALL = 1'b1;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arbState_t;

  // Burst counter width: at least 8 bits, wider only for large burst limits.
  function automatic int cntWidth(input int maxBurst);
    return (maxBurst < 256) ? 8 : $clog2(maxBurst + 1);
  endfunction

endpackage

// File: rtl/parsed_token_arb_rr_pick.sv
// Combinational round-robin first-set finder: the first set req bit at or
// above ptr, wrapping modulo N.
module rr_pick
  import parsed_token_arb_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0] req,
  input  logic [1:0]   ptr,
  output logic [1:0]   idx,
  output logic         any
);

  logic [1:0]   cand [N];
  logic [N-1:0] hit;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : gCand
      assign cand[gi] = 2'((int'(ptr) + gi) % N);
    end
  endgenerate

  // hit[k] is the request bit of the requester k places after ptr.
  always_comb begin
    hit = '0;
    for (int k = 0; k < N; k++) begin
      for (int j = 0; j < N; j++) begin
        if (cand[k] == 2'(j) && req[j]) hit[k] = 1'b1;
      end
    end
  end

  always_comb begin
    idx = '0;
    any = |req;
    for (int k = N - 1; k >= 0; k--) begin
      if (hit[k]) idx = cand[k];
    end
  end

endmodule

// File: rtl/parsed_token_arb.sv
// Packet-locked round-robin arbiter merging up to four token producers into
// one parsed-token queue through a single registered output stage.
module parsed_token_arb
  import parsed_token_arb_pkg::*;
#(
  parameter int W        = TOKEN_W,
  parameter int N        = 2,
  parameter int MAXBURST = 0
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [N*W-1:0] in_d,
  input  logic [N-1:0]   in_e,
  input  logic [N-1:0]   in_v,
  output logic [N-1:0]   in_b,
  output logic [W-1:0]   qout_d,
  output logic           qout_e,
  output logic           qout_v,
  input  logic           qout_b,
  output logic [1:0]     grant,
  output logic           busy
);

  localparam int CW = cntWidth(MAXBURST);

  arbState_t   state, stateNext;
  logic [1:0]  ptr, ptrNext, grantNext;
  logic [CW-1:0] cnt, cntNext, cntInc;
  logic [W-1:0] dNext, selD;
  logic        eNext, vNext, selE, selV;
  logic        room, accept, relFire;
  logic [1:0]  pickIdx;
  logic        pickAny;

  rr_pick #(.N(N)) uPick (
    .req(in_v),
    .ptr(ptr),
    .idx(pickIdx),
    .any(pickAny)
  );

  assign room   = !qout_v || !qout_b;
  assign busy   = (state == LOCKED);
  assign cntInc = cnt + CW'(1);

  // Data, flag and valid of the currently granted requester.
  always_comb begin
    selD = '0;
    selE = 1'b0;
    selV = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (grant == 2'(i)) begin
        selD = in_d[i*W +: W];
        selE = in_e[i];
        selV = in_v[i];
      end
    end
  end

  always_comb begin
    stateNext = state;
    ptrNext   = ptr;
    grantNext = grant;
    cntNext   = cnt;
    dNext     = qout_d;
    eNext     = qout_e;
    vNext     = qout_v;
    in_b      = {N{STALL}};
    accept    = 1'b0;
    relFire   = 1'b0;
    // A drained output register empties unless refilled below.
    if (room) vNext = 1'b0;
    case (state)
      IDLE: begin
        if (pickAny) begin
          grantNext = pickIdx;
          cntNext   = '0;
          stateNext = LOCKED;
        end
      end
      LOCKED: begin
        for (int i = 0; i < N; i++) begin
          if (grant == 2'(i)) in_b[i] = !room;
        end
        accept = selV && room;
        if (accept) begin
          dNext = selD;
          eNext = selE;
          vNext = 1'b1;
          if (cnt != '1) cntNext = cntInc;
          relFire = selE || (MAXBURST != 0 && cntInc == CW'(MAXBURST));
          if (relFire) begin
            stateNext = IDLE;
            ptrNext   = (grant == 2'(N - 1)) ? 2'd0 : grant + 2'd1;
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      ptr    <= '0;
      grant  <= '0;
      cnt    <= '0;
      qout_d <= '0;
      qout_e <= 1'b0;
      qout_v <= 1'b0;
    end else begin
      state  <= stateNext;
      ptr    <= ptrNext;
      grant  <= grantNext;
      cnt    <= cntNext;
      qout_d <= dNext;
      qout_e <= eNext;
      qout_v <= vNext;
    end
  end

endmodule

// File: tb/tb_parsed_token_arb.sv
// Directed bench for parsed_token_arb: a per-cycle vector table plus
// hand-written multi-cycle sequences on an unlimited and a burst-limited instance.
module tb_parsed_token_arb;

  typedef struct {
    logic        rst;
    logic [1:0]  v;
    logic [15:0] d0;
    logic [15:0] d1;
    logic [1:0]  e;
    logic        qb;
    logic [1:0]  expInB;
    logic        expV;
    logic [15:0] expD;
    logic        expE;
    logic        expBusy;
    logic [1:0]  expGrant;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b0;

  logic [31:0] aInD, bInD;
  logic [1:0]  aInE, aInV, aInB, bInE, bInV, bInB;
  logic [15:0] aQD, bQD;
  logic        aQE, aQV, aQB, bQE, bQV, bQB;
  logic [1:0]  aGrant, bGrant;
  logic        aBusy, bBusy;

  int checks = 0;
  int passes = 0;
  vec_t vecs[$];

  always #5 clock = ~clock;

  parsed_token_arb #(.W(16), .N(2), .MAXBURST(0)) dutA (
    .clock(clock), .reset(reset),
    .in_d(aInD), .in_e(aInE), .in_v(aInV), .in_b(aInB),
    .qout_d(aQD), .qout_e(aQE), .qout_v(aQV), .qout_b(aQB),
    .grant(aGrant), .busy(aBusy)
  );

  parsed_token_arb #(.W(16), .N(2), .MAXBURST(4)) dutB (
    .clock(clock), .reset(reset),
    .in_d(bInD), .in_e(bInE), .in_v(bInV), .in_b(bInB),
    .qout_d(bQD), .qout_e(bQE), .qout_v(bQV), .qout_b(bQB),
    .grant(bGrant), .busy(bBusy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic void addVec(input logic rst, input logic [1:0] v, input logic [15:0] d0,
                                 input logic [15:0] d1, input logic [1:0] e, input logic qb,
                                 input logic [1:0] expInB, input logic expV, input logic [15:0] expD,
                                 input logic expE, input logic expBusy, input logic [1:0] expGrant);
    vec_t t;
    t.rst = rst; t.v = v; t.d0 = d0; t.d1 = d1; t.e = e; t.qb = qb;
    t.expInB = expInB; t.expV = expV; t.expD = expD; t.expE = expE;
    t.expBusy = expBusy; t.expGrant = expGrant;
    vecs.push_back(t);
  endfunction

  task automatic doReset();
    reset = 1'b0;
    aInV = '0; aInD = '0; aInE = '0; aQB = 1'b0;
    bInV = '0; bInD = '0; bInE = '0; bQB = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic driveA(input logic [1:0] v, input logic [15:0] d0, input logic [15:0] d1,
                        input logic [1:0] e, input logic qb);
    @(negedge clock);
    aInV = v; aInD = {d1, d0}; aInE = e; aQB = qb;
    #1;
  endtask

  task automatic applyVec(input int idx, input vec_t t);
    if (t.rst) doReset();
    driveA(t.v, t.d0, t.d1, t.e, t.qb);
    $display("vec %0d: in_v=%b in_b=%b qout_v=%b qout_d=%h qout_e=%b busy=%b grant=%0d",
             idx, aInV, aInB, aQV, aQD, aQE, aBusy, aGrant);
    check($sformatf("vec%0d.in_b", idx), 32'(aInB), 32'(t.expInB));
    check($sformatf("vec%0d.qout_v", idx), 32'(aQV), 32'(t.expV));
    check($sformatf("vec%0d.busy", idx), 32'(aBusy), 32'(t.expBusy));
    if (t.expV) begin
      check($sformatf("vec%0d.qout_d", idx), 32'(aQD), 32'(t.expD));
      check($sformatf("vec%0d.qout_e", idx), 32'(aQE), 32'(t.expE));
    end
    if (t.expBusy) check($sformatf("vec%0d.grant", idx), 32'(aGrant), 32'(t.expGrant));
  endtask

  initial begin
    logic [15:0] bpTok [4];
    logic [15:0] got[$];
    int k;
    int n;

    // Single requester: three tokens, last with e=1.
    addVec(1, 2'b01, 16'h0011, 16'h0, 2'b00, 0, 2'b11, 0, 16'h0,    0, 0, 2'd0);
    addVec(0, 2'b01, 16'h0011, 16'h0, 2'b00, 0, 2'b10, 0, 16'h0,    0, 1, 2'd0);
    addVec(0, 2'b01, 16'h0022, 16'h0, 2'b00, 0, 2'b10, 1, 16'h0011, 0, 1, 2'd0);
    addVec(0, 2'b01, 16'h0033, 16'h0, 2'b01, 0, 2'b10, 1, 16'h0022, 0, 1, 2'd0);
    addVec(0, 2'b00, 16'h0,    16'h0, 2'b00, 0, 2'b11, 1, 16'h0033, 1, 0, 2'd0);
    addVec(0, 2'b00, 16'h0,    16'h0, 2'b00, 0, 2'b11, 0, 16'h0,    0, 0, 2'd0);
    // Contention: A0,A1 then B0,B1 then A2,A3.
    addVec(1, 2'b11, 16'h00A0, 16'h00B0, 2'b00, 0, 2'b11, 0, 16'h0,    0, 0, 2'd0);
    addVec(0, 2'b11, 16'h00A0, 16'h00B0, 2'b00, 0, 2'b10, 0, 16'h0,    0, 1, 2'd0);
    addVec(0, 2'b11, 16'h00A1, 16'h00B0, 2'b01, 0, 2'b10, 1, 16'h00A0, 0, 1, 2'd0);
    addVec(0, 2'b11, 16'h00A2, 16'h00B0, 2'b00, 0, 2'b11, 1, 16'h00A1, 1, 0, 2'd0);
    addVec(0, 2'b11, 16'h00A2, 16'h00B0, 2'b00, 0, 2'b01, 0, 16'h0,    0, 1, 2'd1);
    addVec(0, 2'b11, 16'h00A2, 16'h00B1, 2'b10, 0, 2'b01, 1, 16'h00B0, 0, 1, 2'd1);
    addVec(0, 2'b11, 16'h00A2, 16'h00B2, 2'b00, 0, 2'b11, 1, 16'h00B1, 1, 0, 2'd0);
    addVec(0, 2'b11, 16'h00A2, 16'h00B2, 2'b00, 0, 2'b10, 0, 16'h0,    0, 1, 2'd0);
    addVec(0, 2'b11, 16'h00A3, 16'h00B2, 2'b01, 0, 2'b10, 1, 16'h00A2, 0, 1, 2'd0);
    addVec(0, 2'b00, 16'h0,    16'h0,    2'b00, 0, 2'b11, 1, 16'h00A3, 1, 0, 2'd0);
    addVec(0, 2'b00, 16'h0,    16'h0,    2'b00, 0, 2'b11, 0, 16'h0,    0, 0, 2'd0);

    // Reset state.
    doReset();
    #1;
    check("rst.qout_v", 32'(aQV), 32'(0));
    check("rst.qout_d", 32'(aQD), 32'(0));
    check("rst.qout_e", 32'(aQE), 32'(0));
    check("rst.grant", 32'(aGrant), 32'(0));
    check("rst.busy", 32'(aBusy), 32'(0));
    check("rst.in_b", 32'(aInB), 32'(2'b11));
    check("rst.b_in_b", 32'(bInB), 32'(2'b11));

    for (int i = 0; i < vecs.size(); i++) applyVec(i, vecs[i]);

    // Backpressure: three stall cycles while 0x0053 sits on the output.
    bpTok[0] = 16'h0051; bpTok[1] = 16'h0052; bpTok[2] = 16'h0053; bpTok[3] = 16'h0054;
    doReset();
    k = 0;
    for (int c = 0; c < 12; c++) begin
      driveA((k < 4) ? 2'b01 : 2'b00, (k < 4) ? bpTok[k & 3] : 16'h0, 16'h0,
             {1'b0, k == 3}, (c >= 4 && c <= 6));
      $display("bp cycle %0d: in_b=%b qout_v=%b qout_d=%h qout_b=%b", c, aInB, aQV, aQD, aQB);
      if (c >= 4 && c <= 6) begin
        check($sformatf("bp%0d.qout_d", c), 32'(aQD), 32'h0053);
        check($sformatf("bp%0d.qout_v", c), 32'(aQV), 32'(1));
        check($sformatf("bp%0d.in_b0", c), 32'(aInB[0]), 32'(1));
      end
      if (aQV && !aQB) got.push_back(aQD);
      if (aInV[0] && !aInB[0]) k++;
    end
    check("bp.count", 32'(got.size()), 32'(4));
    for (int i = 0; i < 4 && i < got.size(); i++)
      check($sformatf("bp.tok%0d", i), 32'(got[i]), 32'(bpTok[i]));

    // Requester 0 goes quiet for 5 cycles while locked; requester 1 waits.
    doReset();
    driveA(2'b11, 16'h0061, 16'h00C1, 2'b00, 0);
    driveA(2'b11, 16'h0061, 16'h00C1, 2'b00, 0);
    check("idle.grant0", 32'(aGrant), 32'(0));
    for (int c = 0; c < 5; c++) begin
      driveA(2'b10, 16'h0, 16'h00C1, 2'b00, 0);
      $display("idle cycle %0d: in_b=%b busy=%b grant=%0d", c, aInB, aBusy, aGrant);
      check($sformatf("idle%0d.grant", c), 32'(aGrant), 32'(0));
      check($sformatf("idle%0d.busy", c), 32'(aBusy), 32'(1));
      check($sformatf("idle%0d.in_b1", c), 32'(aInB[1]), 32'(1));
    end
    driveA(2'b11, 16'h0062, 16'h00C1, 2'b01, 0);
    check("idle.last_in_b", 32'(aInB), 32'(2'b10));
    driveA(2'b10, 16'h0, 16'h00C1, 2'b00, 0);
    check("idle.gap_busy", 32'(aBusy), 32'(0));
    check("idle.last_tok", 32'(aQD), 32'h0062);
    driveA(2'b10, 16'h0, 16'h00C1, 2'b00, 0);
    check("idle.next_grant", 32'(aGrant), 32'(1));
    check("idle.next_busy", 32'(aBusy), 32'(1));

    // Reset asserted while requester 1 is mid-packet.
    doReset();
    driveA(2'b11, 16'h0071, 16'h0081, 2'b01, 0);
    driveA(2'b11, 16'h0071, 16'h0081, 2'b01, 0);
    driveA(2'b11, 16'h0072, 16'h0081, 2'b00, 0);
    check("mid.gap_busy", 32'(aBusy), 32'(0));
    driveA(2'b11, 16'h0072, 16'h0081, 2'b00, 0);
    check("mid.grant1", 32'(aGrant), 32'(1));
    check("mid.in_b", 32'(aInB), 32'(2'b01));
    driveA(2'b11, 16'h0072, 16'h0082, 2'b00, 0);
    check("mid.pre_v", 32'(aQV), 32'(1));
    reset = 1'b0;
    #1;
    $display("mid reset: qout_v=%b in_b=%b busy=%b grant=%0d", aQV, aInB, aBusy, aGrant);
    check("mid.async_v", 32'(aQV), 32'(0));
    check("mid.async_in_b", 32'(aInB), 32'(2'b11));
    check("mid.async_busy", 32'(aBusy), 32'(0));
    check("mid.async_grant", 32'(aGrant), 32'(0));
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    #1;
    check("mid.restart_grant", 32'(aGrant), 32'(0));
    check("mid.restart_busy", 32'(aBusy), 32'(1));

    // Burst limit 4: requester 1 streams without e while requester 0 waits.
    doReset();
    @(negedge clock);
    bInV = 2'b10; bInD = {16'h0090, 16'h00A0}; bInE = 2'b00; bQB = 1'b0;
    n = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clock);
      bInV = 2'b11; bInD = {16'h0090 + 16'(n), 16'h00A0}; bInE = 2'b00;
      #1;
      $display("burst cycle %0d: in_b=%b busy=%b grant=%0d qout_v=%b qout_d=%h",
               c, bInB, bBusy, bGrant, bQV, bQD);
      if (c <= 4) check($sformatf("burst%0d.grant", c), 32'(bGrant), 32'(1));
      if (c == 5) begin
        check("burst.gap_busy", 32'(bBusy), 32'(0));
        check("burst.last_tok", 32'(bQD), 32'h0093);
      end
      if (c == 6) begin
        check("burst.switch_grant", 32'(bGrant), 32'(0));
        check("burst.switch_in_b1", 32'(bInB[1]), 32'(1));
      end
      if (bInV[1] && !bInB[1]) n++;
    end
    check("burst.req1_count", 32'(n), 32'(4));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
